// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample width, sample type and ws channel decoding.
package i2s_pkg;

  localparam int unsigned I2S_WIDTH = 16;

  typedef logic [I2S_WIDTH-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

endpackage

// File: rtl/i2s_rx.sv
// I2S serial-to-parallel receiver: assembles MSB-first words on sclk and holds the
// most recently completed left and right samples.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = I2S_WIDTH
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             ws,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_chan,
  output logic [WIDTH-1:0] right_chan
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             ws_d_q;
  channel_e         prev_ch;

  always_comb begin
    sr_d    = {sr_q[WIDTH-2:0], sdata};
    prev_ch = channel_e'(ws_d_q);
    left_d  = left_q;
    right_d = right_q;
    // A ws change marks the LSB edge of the word belonging to the previous channel.
    if (ws != ws_d_q) begin
      if (prev_ch == CH_LEFT) begin
        left_d = sr_d;
      end else begin
        right_d = sr_d;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      sr_q    <= '0;
      ws_d_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      sr_q    <= sr_d;
      ws_d_q  <= ws;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives ws/sdata on falling sclk, checks outputs 1ns after rising sclk.
module tb_i2s_rx;

  logic        sclk;
  logic        rst;
  logic        ws;
  logic        sdata;
  logic [15:0] left_chan;
  logic [15:0] right_chan;

  int checks   = 0;
  int failures = 0;

  i2s_rx #(.WIDTH(16)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .ws        (ws),
    .sdata     (sdata),
    .left_chan (left_chan),
    .right_chan(right_chan)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bit period: drive on falling edge, return 1ns after the sampling edge.
  task automatic send_bit(input logic b, input logic w);
    @(negedge sclk);
    sdata = b;
    ws    = w;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_msbs(input logic [15:0] word, input logic cur);
    for (int i = 15; i >= 1; i--) send_bit(word[i], cur);
  endtask

  task automatic send_word(input logic [15:0] word, input logic cur, input logic nxt);
    send_msbs(word, cur);
    send_bit(word[0], nxt);
  endtask

  initial begin
    logic [15:0] partial;
    rst   = 1'b1;
    ws    = 1'b0;
    sdata = 1'b0;
    repeat (10) @(posedge sclk);
    #1;
    chk("reset_left_held", left_chan, 16'h0000);
    chk("reset_right_held", right_chan, 16'h0000);
    @(negedge sclk);
    rst = 1'b0;
    @(posedge sclk);
    #1;
    chk("reset_left", left_chan, 16'h0000);
    chk("reset_right", right_chan, 16'h0000);

    // Frame 1 with exact-edge checks
    send_msbs(16'hDEAD, 1'b0);
    chk("f1_left_before_lsb", left_chan, 16'h0000);
    send_bit(1'b1, 1'b1);
    chk("f1_left_at_lsb", left_chan, 16'hDEAD);
    chk("f1_right_untouched", right_chan, 16'h0000);
    send_msbs(16'hBEEF, 1'b1);
    chk("f1_right_before_lsb", right_chan, 16'h0000);
    send_bit(1'b1, 1'b0);
    chk("f1_right_at_lsb", right_chan, 16'hBEEF);
    chk("f1_left_held", left_chan, 16'hDEAD);
    send_bit(1'b0, 1'b0);
    chk("f1_idle_left", left_chan, 16'hDEAD);
    chk("f1_idle_right", right_chan, 16'hBEEF);

    // Frame 2 then one idle clock
    send_word(16'h1234, 1'b0, 1'b1);
    chk("f2_left", left_chan, 16'h1234);
    chk("f2_right_untouched", right_chan, 16'hBEEF);
    send_word(16'h5678, 1'b1, 1'b0);
    chk("f2_right", right_chan, 16'h5678);
    send_bit(1'b1, 1'b0);
    chk("f2_idle_left", left_chan, 16'h1234);
    chk("f2_idle_right", right_chan, 16'h5678);

    // Back-to-back frames
    send_word(16'hAAAA, 1'b0, 1'b1);
    chk("b2b_left1", left_chan, 16'hAAAA);
    send_word(16'h5555, 1'b1, 1'b0);
    chk("b2b_right1", right_chan, 16'h5555);
    send_word(16'h0001, 1'b0, 1'b1);
    chk("b2b_left2", left_chan, 16'h0001);
    chk("b2b_right1_held", right_chan, 16'h5555);
    send_msbs(16'h8000, 1'b1);
    chk("b2b_right_before_lsb", right_chan, 16'h5555);
    send_bit(1'b0, 1'b0);
    chk("b2b_right2", right_chan, 16'h8000);

    // Long idle with random data
    for (int i = 0; i < 40; i++) begin
      send_bit(1'($urandom_range(1, 0)), 1'b0);
      chk("idle_left", left_chan, 16'h0001);
      chk("idle_right", right_chan, 16'h8000);
    end

    // Over-length left word: four extra leading ones are discarded
    repeat (4) send_bit(1'b1, 1'b0);
    send_word(16'h0F0F, 1'b0, 1'b1);
    chk("long_left", left_chan, 16'h0F0F);
    send_word(16'h4321, 1'b1, 1'b0);
    chk("long_right", right_chan, 16'h4321);

    // Reset mid-left-word
    partial = 16'h1357;
    for (int i = 15; i >= 8; i--) send_bit(partial[i], 1'b0);
    @(negedge sclk);
    rst = 1'b1;
    @(posedge sclk);
    #1;
    chk("midrst_left", left_chan, 16'h0000);
    chk("midrst_right", right_chan, 16'h0000);
    rst = 1'b0;
    send_word(16'hCAFE, 1'b0, 1'b1);
    chk("post_rst_left", left_chan, 16'hCAFE);
    chk("post_rst_right_untouched", right_chan, 16'h0000);
    send_word(16'hF00D, 1'b1, 1'b0);
    chk("post_rst_right", right_chan, 16'hF00D);
    chk("post_rst_left_held", left_chan, 16'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
